id_stage: RTL
=============

# id_stage

Instruction-decode stage of the 4-thread pipeline: decodes one 32-bit instruction per cycle, reads two operands from a thread-banked register file, and produces the control, operand, sign-extended immediate and destination fields that the ID/EX pipeline register captures. It owns the register file, whose write port is driven by the write-back stage. After reset it runs a clear sequence, sweeping every register to zero before accepting instructions.

## Interface
- PROC_DATA_WIDTH, 16, register/operand width
- PROC_REGFILE_LOG2_DEEP, 5, log2 of registers per thread
- THREAD_LOG2, 2, log2 of hardware thread count
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- instr_in  in  32  instruction word
- instr_valid_in  in  1  instr_in and thread_id_in are valid this cycle
- thread_id_in  in  THREAD_LOG2  issuing thread
- wb_en_in  in  1  write-back enable
- wb_thread_in  in  THREAD_LOG2  write-back thread
- wb_addr_in  in  PROC_REGFILE_LOG2_DEEP  write-back register
- wb_data_in  in  PROC_DATA_WIDTH  write-back data
- id_ready  out  1  clear sequence finished; decode active
- WRegEn_out, WMemEn_out, rs2_swch_out, mem_to_reg_out  out  1 each  control to ID/EX
- R1out_out, R2out_out, sign_ext_out  out  PROC_DATA_WIDTH  rs1 value, rs2 value, immediate
- WReg1_out  out  PROC_REGFILE_LOG2_DEEP  destination register
- func3_out  out  3; func7_out  out  1; thread_id_out  out  THREAD_LOG2

## Operation
- FSM states: INIT and RUN. RST high forces INIT with clear counter = 0. This applies in any state, so reset mid-operation restarts the sweep.
- INIT, RST low: each cycle, register[cnt] of all threads is written to 0, then cnt increments. The cycle that clears index 2^LOG2_DEEP−1 moves the FSM to RUN.
- Write-back requests in INIT are dropped.
- RUN: when wb_en_in is high and wb_addr_in ≠ 0, register[wb_thread_in][wb_addr_in] is written with wb_data_in. Writes to x0 are ignored.
- Reads are combinational:
  - rs1 = instr[19:15], rs2 = instr[24:20].
  - Register index 0 always reads 0.
  - Same-cycle bypass: if wb_en_in is high, wb_thread_in == thread_id_in, and wb_addr_in == rs ≠ 0, the operand equals wb_data_in.
- Decode on instr[6:0], applied only when instr_valid_in is high and the FSM is in RUN:
  - 0110011 R-type: WRegEn = 1, rs2_swch = 0, sign_ext = 0.
  - 0010011 I-ALU: WRegEn = 1, rs2_swch = 1, sign_ext = instr[31:20] sign-extended.
  - 0000011 LOAD: WRegEn = 1, mem_to_reg = 1, rs2_swch = 1, I-immediate.
  - 0100011 STORE: WMemEn = 1, rs2_swch = 1, sign_ext = {instr[31:25], instr[11:7]} sign-extended.
  - Any other opcode is a NOP: all four control outputs are 0.
- func3_out = instr[14:12]. WReg1_out = instr[11:7]. thread_id_out = thread_id_in.
- func7_out = instr[30] for R-type, and for I-ALU when func3 = 101. It is 0 otherwise.
- WRegEn is forced to 0 when rd = 0.
- Immediate width rule: the 12-bit immediate is sign-extended to 16 bits, taking bit 11 as the sign.
- Bubble: when instr_valid_in is low or the FSM is in INIT, every output except id_ready is 0. This includes operands, immediate and IDs.

## Timing
- Decode and operand outputs are combinational from the inputs plus register-file state; latency to ID/EX is 0 cycles.
- Register-file writes become visible to the array on the next edge. A same-cycle read sees the write through the bypass.
- Reset values:
  - While RST is high, all outputs are 0 and id_ready is 0.
  - id_ready rises after exactly 2^PROC_REGFILE_LOG2_DEEP (32) rising edges with RST low.
- Simultaneous events:
  - A clear-sweep write beats write-back.
  - RST beats everything.
  - In RUN, write-back and decode coexist in the same cycle with no stall.

## Structure
- Shared package holds the opcode constants (OP_R, OP_IALU, OP_LOAD, OP_STORE), NUM_THREADS = 2^THREAD_LOG2, and an immediate-extract function. The existing ID/EX and EX stages import the same package.
- One sub-module, thread_regfile, holds the 2^THREAD_LOG2 × 2^LOG2_DEEP × PROC_DATA_WIDTH array. It has one synchronous write port, a bank-wide clear write, and two combinational read ports with x0 forced to zero.
- Bypass, decode and FSM stay in id_stage.

## Test plan
- Hold RST for 3 cycles, then release → id_ready = 0 for 31 edges and 1 after the 32nd; every register of every thread reads 0.
- Write thread 2, x5 = 0x1234 via WB; next cycle decode R-type add with rs1 = 5 on thread 2 → R1out_out = 0x1234. The same instruction on thread 1 → 0x0000.
- Same cycle: WB thread 0, x7 = 0xBEEF, and decode thread 0 with rs2 = 7 → R2out_out = 0xBEEF through the bypass. A WB to x0 → later read of x0 = 0.
- addi with imm = 0xFFF → sign_ext_out = 0xFFFF, rs2_swch = 1, WRegEn = 1, func7_out = 0. srai (func3 = 101, instr[30] = 1) → func7_out = 1.
- Store with imm = −4 → sign_ext_out = 0xFFFC, WMemEn = 1, WRegEn = 0. Load with rd = 0 → WRegEn = 0, mem_to_reg = 1. Opcode 1111111 → all controls 0.
- Assert RST for 1 cycle mid-run, after a WB of 0x55AA → id_ready drops, outputs go to 0, and the sweep restarts. After 32 edges the register reads 0. A WB issued during INIT is lost.

Source files
------------

// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pkg
// Description : Opcodes, thread count, FSM encoding and immediate helper
//               shared by the decode and execute stages.
// Revision    : 1.0
// ============================================================================
package id_stage_pkg;

  localparam int DEFAULT_THREAD_LOG2 = 2;
  localparam int NUM_THREADS         = 2 ** DEFAULT_THREAD_LOG2;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } id_state_t;

  // hi12 = instr[31:20], lo5 = instr[11:7]; stores split the immediate.
  function automatic logic [11:0] imm_extract(input logic [6:0]  opcode,
                                              input logic [11:0] hi12,
                                              input logic [4:0]  lo5);
    logic [11:0] imm;
    if (opcode == OP_STORE) imm = {hi12[11:5], lo5};
    else                    imm = hi12;
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_thread_regfile.sv
`default_nettype none
// ============================================================================
// Module      : thread_regfile
// Description : Thread-banked register file, one write port, a bank-wide
//               clear write and two combinational read ports (x0 reads 0).
// Revision    : 1.0
// ============================================================================
module thread_regfile #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOG2_DEEP   = 5,
  parameter int THREAD_LOG2 = 2
) (
  input  logic                   CLK,
  input  logic                   wr_en,
  input  logic [THREAD_LOG2-1:0] wr_thread,
  input  logic [LOG2_DEEP-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   clr_en,
  input  logic [LOG2_DEEP-1:0]   clr_addr,
  input  logic [THREAD_LOG2-1:0] rd_thread,
  input  logic [LOG2_DEEP-1:0]   rd_addr1,
  input  logic [LOG2_DEEP-1:0]   rd_addr2,
  output logic [DATA_WIDTH-1:0]  rd_data1,
  output logic [DATA_WIDTH-1:0]  rd_data2
);

  localparam int C_THREADS = 2 ** THREAD_LOG2;
  localparam int C_DEPTH   = 2 ** LOG2_DEEP;

  logic [DATA_WIDTH-1:0] r_mem [C_THREADS][C_DEPTH];

  // The clear sweep owns the array; a concurrent write is discarded.
  always_ff @(posedge CLK) begin
    for (int t = 0; t < C_THREADS; t++) begin
      if (clr_en) begin
        r_mem[t][clr_addr] <= '0;
      end else if (wr_en && (wr_thread == THREAD_LOG2'(t)) && (wr_addr != '0)) begin
        r_mem[t][wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != '0) rd_data1 = r_mem[rd_thread][rd_addr1];
    if (rd_addr2 != '0) rd_data2 = r_mem[rd_thread][rd_addr2];
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Instruction decode with operand read, write-back bypass and
//               post-reset register-file clear sequence.
// Revision    : 1.0
// ============================================================================
module id_stage
  import id_stage_pkg::*;
#(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5,
  parameter int THREAD_LOG2            = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [31:0]                       instr_in,
  input  logic                              instr_valid_in,
  input  logic [THREAD_LOG2-1:0]            thread_id_in,
  input  logic                              wb_en_in,
  input  logic [THREAD_LOG2-1:0]            wb_thread_in,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_addr_in,
  input  logic [PROC_DATA_WIDTH-1:0]        wb_data_in,
  output logic                              id_ready,
  output logic                              WRegEn_out,
  output logic                              WMemEn_out,
  output logic                              rs2_swch_out,
  output logic                              mem_to_reg_out,
  output logic [PROC_DATA_WIDTH-1:0]        R1out_out,
  output logic [PROC_DATA_WIDTH-1:0]        R2out_out,
  output logic [PROC_DATA_WIDTH-1:0]        sign_ext_out,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_out,
  output logic [2:0]                        func3_out,
  output logic                              func7_out,
  output logic [THREAD_LOG2-1:0]            thread_id_out
);

  localparam int C_EXT_W = PROC_DATA_WIDTH - 12;

  id_state_t                         r_state;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] r_cnt;

  logic                              w_run;
  logic                              w_active;
  logic [6:0]                        w_opcode;
  logic [2:0]                        w_func3;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] w_rs1;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] w_rs2;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] w_rd;
  logic                              w_rd_nz;
  logic [PROC_DATA_WIDTH-1:0]        w_rf1;
  logic [PROC_DATA_WIDTH-1:0]        w_rf2;
  logic [PROC_DATA_WIDTH-1:0]        w_op1;
  logic [PROC_DATA_WIDTH-1:0]        w_op2;
  logic [11:0]                       w_imm12;
  logic [PROC_DATA_WIDTH-1:0]        w_imm_ext;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // RST gates everything combinationally so outputs are quiet from its first cycle.
  assign w_run    = (r_state == ST_RUN) && !RST;
  assign w_active = instr_valid_in && w_run;
  assign id_ready = w_run;

  assign w_opcode  = instr_in[6:0];
  assign w_func3   = instr_in[14:12];
  assign w_rs1     = PROC_REGFILE_LOG2_DEEP'(instr_in[19:15]);
  assign w_rs2     = PROC_REGFILE_LOG2_DEEP'(instr_in[24:20]);
  assign w_rd      = PROC_REGFILE_LOG2_DEEP'(instr_in[11:7]);
  assign w_rd_nz   = (w_rd != '0);
  assign w_imm12   = imm_extract(w_opcode, instr_in[31:20], instr_in[11:7]);
  assign w_imm_ext = {{C_EXT_W{w_imm12[11]}}, w_imm12};

  thread_regfile #(
    .DATA_WIDTH  (PROC_DATA_WIDTH),
    .LOG2_DEEP   (PROC_REGFILE_LOG2_DEEP),
    .THREAD_LOG2 (THREAD_LOG2)
  ) u_regfile (
    .CLK       (CLK),
    .wr_en     (wb_en_in && w_run),
    .wr_thread (wb_thread_in),
    .wr_addr   (wb_addr_in),
    .wr_data   (wb_data_in),
    .clr_en    ((r_state == ST_INIT) && !RST),
    .clr_addr  (r_cnt),
    .rd_thread (thread_id_in),
    .rd_addr1  (w_rs1),
    .rd_addr2  (w_rs2),
    .rd_data1  (w_rf1),
    .rd_data2  (w_rf2)
  );

  // Write-back forwarding for a same-cycle read of the register being written.
  always_comb begin
    w_op1 = w_rf1;
    w_op2 = w_rf2;
    if (wb_en_in && (wb_thread_in == thread_id_in)) begin
      if ((wb_addr_in == w_rs1) && (w_rs1 != '0)) w_op1 = wb_data_in;
      if ((wb_addr_in == w_rs2) && (w_rs2 != '0)) w_op2 = wb_data_in;
    end
  end

  always_comb begin
    WRegEn_out     = 1'b0;
    WMemEn_out     = 1'b0;
    rs2_swch_out   = 1'b0;
    mem_to_reg_out = 1'b0;
    R1out_out      = '0;
    R2out_out      = '0;
    sign_ext_out   = '0;
    WReg1_out      = '0;
    func3_out      = '0;
    func7_out      = 1'b0;
    thread_id_out  = '0;
    if (w_active) begin
      R1out_out     = w_op1;
      R2out_out     = w_op2;
      WReg1_out     = w_rd;
      func3_out     = w_func3;
      thread_id_out = thread_id_in;
      case (w_opcode)
        OP_R: begin
          WRegEn_out = w_rd_nz;
          func7_out  = instr_in[30];
        end
        OP_IALU: begin
          WRegEn_out   = w_rd_nz;
          rs2_swch_out = 1'b1;
          sign_ext_out = w_imm_ext;
          func7_out    = instr_in[30] && (w_func3 == 3'b101);
        end
        OP_LOAD: begin
          WRegEn_out     = w_rd_nz;
          mem_to_reg_out = 1'b1;
          rs2_swch_out   = 1'b1;
          sign_ext_out   = w_imm_ext;
        end
        OP_STORE: begin
          WMemEn_out   = 1'b1;
          rs2_swch_out = 1'b1;
          sign_ext_out = w_imm_ext;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
